// File: rtl/packet_buffer_writer.sv
// Ingress writer: prefixes each packet with a 2-byte big-endian length and commits it into a circular RAM.
// Optional: define PKT_WR_MIN_LEN_EN to drop packets shorter than MIN_PKT_LEN.
module packet_buffer_writer #(
  parameter int RAM_SIZE    = 2048,
  parameter int BYTE_LEN    = 8,
  parameter int MAX_PKT_LEN = 1518,
  parameter int MIN_PKT_LEN = 60,
  localparam int AW = $clog2(RAM_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [BYTE_LEN-1:0] in_data,
  input  logic                in_last,
  input  logic                in_err,
  output logic                in_ready,
  input  logic [AW-1:0]       rd_ptr,
  output logic                wea,
  output logic [AW-1:0]       addra,
  output logic [BYTE_LEN-1:0] dina,
  output logic [AW-1:0]       commit_ptr,
  output logic                pkt_done,
  output logic [15:0]         pkt_len,
  output logic                drop,
  output logic [15:0]         drop_count
);

`ifdef PKT_WR_MIN_LEN_EN
  localparam bit MIN_LEN_EN = 1'b1;
`else
  localparam bit MIN_LEN_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, DATA, HDR_HI, HDR_LO, DROP} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pkt_start;
  logic [15:0]   len;

  logic          xfer;
  logic [AW-1:0] free;
  logic          full;
  logic          len_max;
  logic [15:0]   len_next;
  logic          bad_one;
  logic          bad_next;
  logic          drop_evt;

  assign in_ready = !rst && (state == IDLE || state == DATA || state == DROP);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    free     = rd_ptr - commit_ptr - AW'(1);
    full     = (wr_ptr + AW'(1)) == rd_ptr;
    len_max  = len >= 16'(MAX_PKT_LEN);
    len_next = len + 16'd1;
    // A terminating byte is bad if errored or, with the minimum-length check enabled, too short
    bad_one  = in_err || (MIN_LEN_EN && (16'd1 < 16'(MIN_PKT_LEN)));
    bad_next = in_err || (MIN_LEN_EN && (len_next < 16'(MIN_PKT_LEN)));
    drop_evt = 1'b0;
    if (xfer) begin
      case (state)
        IDLE:    drop_evt = (free < AW'(3)) || (in_last && bad_one);
        DATA:    drop_evt = full || len_max || (in_last && bad_next);
        default: drop_evt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      pkt_start  <= '0;
      len        <= '0;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      commit_ptr <= '0;
      pkt_done   <= 1'b0;
      pkt_len    <= '0;
      drop       <= 1'b0;
      drop_count <= '0;
    end else begin
      wea      <= 1'b0;
      pkt_done <= 1'b0;
      drop     <= 1'b0;
      unique case (state)
        IDLE: if (xfer) begin
          pkt_start <= commit_ptr;
          len       <= 16'd1;
          if (free >= AW'(3)) begin
            wea    <= 1'b1;
            addra  <= commit_ptr + AW'(2);
            dina   <= in_data;
            wr_ptr <= commit_ptr + AW'(3);
            state  <= in_last ? (bad_one ? IDLE : HDR_HI) : DATA;
          end else begin
            state  <= in_last ? IDLE : DROP;
          end
        end
        DATA: if (xfer) begin
          if (full || len_max) begin
            state <= in_last ? IDLE : DROP;
          end else begin
            wea    <= 1'b1;
            addra  <= wr_ptr;
            dina   <= in_data;
            wr_ptr <= wr_ptr + AW'(1);
            len    <= len_next;
            if (in_last) state <= bad_next ? IDLE : HDR_HI;
          end
        end
        HDR_HI: begin
          wea   <= 1'b1;
          addra <= pkt_start;
          dina  <= BYTE_LEN'(len[15:8]);
          state <= HDR_LO;
        end
        HDR_LO: begin
          wea        <= 1'b1;
          addra      <= pkt_start + AW'(1);
          dina       <= BYTE_LEN'(len[7:0]);
          commit_ptr <= wr_ptr;
          pkt_len    <= len;
          pkt_done   <= 1'b1;
          state      <= IDLE;
        end
        DROP: if (xfer && in_last) state <= IDLE;
        default: state <= IDLE;
      endcase
      // Placed after the case so the rewind overrides any pointer advance above
      if (drop_evt) begin
        drop   <= 1'b1;
        wr_ptr <= commit_ptr;
        if (drop_count != '1) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule
